rto_timed_output: RTL and testbench

- Downstream consumer of the AXI-to-FIFO bridge. Accepts 128-bit timestamped entries on the bridge's rto_core_* write interface and buffers them in an internal FIFO.
- Releases each entry's 64-bit payload on the output port when a free-running 64-bit time counter reaches the entry's timestamp.
- Reports full/empty back to the bridge and raises sticky overflow/late flags.

---
 rtl/rto_timed_output.sv | 169 ++++++++++++++++
 tb/tb_rto_timed_output.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rto_timed_output.sv
// Timed output stage: buffers {timestamp, payload} entries and releases each
// payload when the free-running time counter reaches its timestamp.
module rto_timed_output #(
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned FIFO_ADDR_WIDTH = 6,
  parameter int unsigned TIME_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic                             rto_core_reset,
  input  logic                             rto_core_flush,
  input  logic                             rto_core_write,
  input  logic [TIME_WIDTH+DATA_WIDTH-1:0] rto_core_fifo_din,
  output logic                             rto_core_full,
  output logic                             rto_core_empty,
  output logic [DATA_WIDTH-1:0]            rto_out_data,
  output logic                             rto_out_valid,
  output logic [TIME_WIDTH-1:0]            rto_time,
  output logic                             rto_overflow,
  output logic                             rto_late
);

  localparam int unsigned ENTRY_W = TIME_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W   = FIFO_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ENTRY_W-1:0]         mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [ENTRY_W-1:0]         rd_data_q;
  logic [TIME_WIDTH-1:0]      head_ts_q;
  logic [DATA_WIDTH-1:0]      head_data_q;
  logic                       head_valid_q;
  logic                       fifo_full_c, wr_en_c, rd_en_c, release_c, head_load_c;

  // Writes are refused when full and discarded outright during a flush.
  assign fifo_full_c = (count_q == CNT_FULL);
  assign wr_en_c     = rto_core_write && !fifo_full_c && !rto_core_flush;

  // Head FSM: state register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)      state_q <= IDLE;
    else if (rto_core_reset) state_q <= IDLE;
    else                     state_q <= state_d;
  end

  // Head FSM: next state, FIFO read request and release decision.
  always_comb begin
    state_d     = state_q;
    rd_en_c     = 1'b0;
    release_c   = 1'b0;
    head_load_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          rd_en_c = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        head_load_c = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (head_valid_q && (rto_time >= head_ts_q)) begin
          release_c = 1'b1;
          if (count_q != '0) begin
            rd_en_c = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush abandons any fetch in progress; a matched release still goes out.
    if (rto_core_flush) begin
      rd_en_c     = 1'b0;
      head_load_c = 1'b0;
      state_d     = IDLE;
    end
    count_d = rto_core_flush ? '0
                             : CNT_W'(count_q + CNT_W'(wr_en_c) - CNT_W'(rd_en_c));
  end

  // Entry storage (no reset needed; validity is tracked by the count).
  always_ff @(posedge s_axi_aclk) begin
    if (wr_en_c && !rto_core_reset) mem[wr_ptr_q] <= rto_core_fifo_din;
  end

  // FIFO pointers, occupancy and registered read port.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else if (rto_core_reset || rto_core_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_c) wr_ptr_q <= FIFO_ADDR_WIDTH'(wr_ptr_q + 1'b1);
      if (rd_en_c) begin
        rd_ptr_q  <= FIFO_ADDR_WIDTH'(rd_ptr_q + 1'b1);
        rd_data_q <= mem[rd_ptr_q];
      end
      count_q <= count_d;
    end
  end

  // Head register holding the oldest entry awaiting its release time.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      head_ts_q    <= '0;
      head_data_q  <= '0;
      head_valid_q <= 1'b0;
    end else if (rto_core_reset) begin
      head_valid_q <= 1'b0;
    end else if (head_load_c) begin
      head_ts_q    <= rd_data_q[ENTRY_W-1:DATA_WIDTH];
      head_data_q  <= rd_data_q[DATA_WIDTH-1:0];
      head_valid_q <= 1'b1;
    end else if (rto_core_flush || (release_c && (state_d == IDLE))) begin
      head_valid_q <= 1'b0;
    end
  end

  // Time counter, release outputs, sticky flags and status.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rto_time       <= '0;
      rto_out_data   <= '0;
      rto_out_valid  <= 1'b0;
      rto_overflow   <= 1'b0;
      rto_late       <= 1'b0;
      rto_core_full  <= 1'b0;
      rto_core_empty <= 1'b1;
    end else if (rto_core_reset) begin
      rto_time       <= '0;
      rto_out_data   <= '0;
      rto_out_valid  <= 1'b0;
      rto_overflow   <= 1'b0;
      rto_late       <= 1'b0;
      rto_core_full  <= 1'b0;
      rto_core_empty <= 1'b1;
    end else begin
      rto_time      <= TIME_WIDTH'(rto_time + 1'b1);
      rto_out_valid <= release_c;
      if (release_c) begin
        rto_out_data <= head_data_q;
        if (rto_time > head_ts_q) rto_late <= 1'b1;
      end
      if (rto_core_write && fifo_full_c && !rto_core_flush) rto_overflow <= 1'b1;
      rto_core_full  <= (count_d == CNT_FULL);
      rto_core_empty <= (count_d == '0) && (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_rto_timed_output.sv
// Bench for rto_timed_output: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rto_timed_output;

  localparam int unsigned DEPTH = 64;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         creset = 1'b0;
  logic         flush = 1'b0;
  logic         write = 1'b0;
  logic [127:0] din = '0;
  logic         rto_core_full, rto_core_empty, rto_out_valid, rto_overflow, rto_late;
  logic [63:0]  rto_out_data, rto_time;

  rto_timed_output dut (
    .s_axi_aclk       (clk),
    .s_axi_aresetn    (aresetn),
    .rto_core_reset   (creset),
    .rto_core_flush   (flush),
    .rto_core_write   (write),
    .rto_core_fifo_din(din),
    .rto_core_full    (rto_core_full),
    .rto_core_empty   (rto_core_empty),
    .rto_out_data     (rto_out_data),
    .rto_out_valid    (rto_out_valid),
    .rto_time         (rto_time),
    .rto_overflow     (rto_overflow),
    .rto_late         (rto_late)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, plus the entry currently taken from it.
  // An entry taken at edge p is eligible for release from edge p+2 onwards.
  logic [127:0]    mq[$];
  logic [63:0]     m_time = '0, m_out_data = '0, held_ts = '0, held_data = '0;
  logic            m_valid = 1'b0, m_ovf = 1'b0, m_late = 1'b0, held_v = 1'b0;
  longint unsigned edge_n = 0, held_ready = 0;
  logic            m_rel, m_pop, m_full;
  logic [127:0]    m_e;

  // Release events observed on the DUT: {decision time, payload} and late flag.
  logic [127:0] dut_log[$];
  logic         dut_late[$];

  task automatic model_clear();
    mq.delete();
    m_time     = '0;
    m_out_data = '0;
    m_valid    = 1'b0;
    m_ovf      = 1'b0;
    m_late     = 1'b0;
    held_v     = 1'b0;
  endtask

  always @(negedge aresetn) model_clear();

  always @(posedge clk) begin
    if (!aresetn || creset) begin
      model_clear();
    end else begin
      m_rel  = held_v && (edge_n >= held_ready) && (m_time >= held_ts);
      m_pop  = !flush && (mq.size() != 0) && (!held_v || m_rel);
      m_full = (mq.size() == DEPTH);
      m_valid = m_rel;
      if (m_rel) begin
        m_out_data = held_data;
        if (m_time > held_ts) m_late = 1'b1;
      end
      if (m_pop) begin
        m_e        = mq.pop_front();
        held_ts    = m_e[127:64];
        held_data  = m_e[63:0];
        held_ready = edge_n + 2;
        held_v     = 1'b1;
      end else if (m_rel) begin
        held_v = 1'b0;
      end
      if (flush) begin
        mq.delete();
        held_v = 1'b0;
      end else if (write) begin
        if (m_full) m_ovf = 1'b1;
        else        mq.push_back(din);
      end
      m_time = m_time + 64'd1;
    end
    edge_n++;
    #1;
    chk("out_valid", 64'(rto_out_valid), 64'(m_valid));
    chk("out_data", rto_out_data, m_out_data);
    chk("time", rto_time, m_time);
    chk("full", 64'(rto_core_full), 64'(mq.size() == DEPTH));
    chk("empty", 64'(rto_core_empty), 64'((mq.size() == 0) && !held_v));
    chk("overflow", 64'(rto_overflow), 64'(m_ovf));
    chk("late", 64'(rto_late), 64'(m_late));
    if (rto_out_valid) begin
      dut_log.push_back({rto_time - 64'd1, rto_out_data});
      dut_late.push_back(rto_late);
    end
  end

  // One input cycle, starting and ending at a falling edge.
  task automatic cyc(input logic w, input logic [127:0] d, input logic fl, input logic cr);
    write  = w;
    din    = d;
    flush  = fl;
    creset = cr;
    @(negedge clk);
    write  = 1'b0;
    flush  = 1'b0;
    creset = 1'b0;
  endtask

  task automatic wait_time(input logic [63:0] t);
    int n = 0;
    while (rto_time != t && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (rto_time != t) chk("wait_time_timeout", rto_time, t);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    dut_log.delete();
    dut_late.delete();
  endtask

  initial begin
    int unsigned r, k;
    logic        burst;
    logic [63:0] ts;

    // Reset state
    do_reset();
    chk("rst_time", rto_time, 64'd0);
    chk("rst_empty", 64'(rto_core_empty), 64'd1);
    chk("rst_full", 64'(rto_core_full), 64'd0);
    chk("rst_valid", 64'(rto_out_valid), 64'd0);
    chk("rst_data", rto_out_data, 64'd0);

    // Single on-time entry
    wait_time(64'd10);
    cyc(1'b1, {64'd100, 64'hA5A5}, 1'b0, 1'b0);
    wait_time(64'd115);
    chk("t1_count", 64'(dut_log.size()), 64'd1);
    if (dut_log.size() == 1) begin
      chk("t1_time", dut_log[0][127:64], 64'd100);
      chk("t1_data", dut_log[0][63:0], 64'hA5A5);
      chk("t1_late", 64'(dut_late[0]), 64'd0);
    end
    chk("t1_empty", 64'(rto_core_empty), 64'd1);

    // Close timestamps are spaced two cycles apart
    do_reset();
    wait_time(64'd5);
    for (int i = 0; i < 3; i++) cyc(1'b1, {64'(50 + i), 64'(16'hB000 + i)}, 1'b0, 1'b0);
    wait_time(64'd60);
    chk("t2_count", 64'(dut_log.size()), 64'd3);
    for (int i = 0; i < dut_log.size() && i < 3; i++) begin
      chk("t2_time", dut_log[i][127:64], 64'(50 + 2 * i));
      chk("t2_data", dut_log[i][63:0], 64'(16'hB000 + i));
      chk("t2_late", 64'(dut_late[i]), 64'(i != 0));
    end

    // Fill to full; the first entry sits in the head, so 64 more fill the FIFO
    do_reset();
    for (int i = 0; i < 66; i++) cyc(1'b1, {64'(1000 + i), 64'(16'hD000 + i)}, 1'b0, 1'b0);
    chk("t3_full", 64'(rto_core_full), 64'd1);
    chk("t3_overflow", 64'(rto_overflow), 64'd1);
    wait_time(64'd1150);
    chk("t3_count", 64'(dut_log.size()), 64'd65);
    for (int i = 0; i < dut_log.size() && i < 65; i++)
      chk("t3_order", dut_log[i][63:0], 64'(16'hD000 + i));
    if (dut_log.size() > 0) chk("t3_first_time", dut_log[0][127:64], 64'd1000);
    chk("t3_empty", 64'(rto_core_empty), 64'd1);

    // Entry already in the past: released three cycles after the write, late
    do_reset();
    wait_time(64'd30);
    cyc(1'b1, {64'd20, 64'h77}, 1'b0, 1'b0);
    wait_time(64'd40);
    chk("t4_count", 64'(dut_log.size()), 64'd1);
    if (dut_log.size() == 1) begin
      chk("t4_time", dut_log[0][127:64], 64'd33);
      chk("t4_late", 64'(dut_late[0]), 64'd1);
    end

    // Flush with a concurrent write
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, {64'(500 + i), 64'(i)}, 1'b0, 1'b0);
    wait_time(64'd100);
    cyc(1'b1, {64'd505, 64'hEE}, 1'b1, 1'b0);
    chk("t5_empty", 64'(rto_core_empty), 64'd1);
    chk("t5_overflow", 64'(rto_overflow), 64'd0);
    wait_time(64'd520);
    chk("t5_no_output", 64'(dut_log.size()), 64'd0);

    // Soft reset in the middle of a wait
    do_reset();
    cyc(1'b1, {64'd0, 64'h1}, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, {64'(300 + i), 64'(i)}, 1'b0, 1'b0);
    wait_time(64'd200);
    chk("t6_late_before", 64'(rto_late), 64'd1);
    dut_log.delete();
    dut_late.delete();
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t6_time_restart", rto_time, 64'd0);
    chk("t6_late_cleared", 64'(rto_late), 64'd0);
    chk("t6_empty", 64'(rto_core_empty), 64'd1);
    wait_time(64'd320);
    chk("t6_no_output", 64'(dut_log.size()), 64'd0);

    // Asynchronous reset mid-stream, checked before any clock edge
    cyc(1'b1, {64'd0, 64'h2}, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, {64'(400 + i), 64'(i)}, 1'b0, 1'b0);
    wait_time(64'd350);
    chk("t7_late_before", 64'(rto_late), 64'd1);
    dut_log.delete();
    dut_late.delete();
    #2 aresetn = 1'b0;
    #1;
    chk("t7_async_time", rto_time, 64'd0);
    chk("t7_async_late", 64'(rto_late), 64'd0);
    chk("t7_async_empty", 64'(rto_core_empty), 64'd1);
    chk("t7_async_valid", 64'(rto_out_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    wait_time(64'd420);
    chk("t7_no_output", 64'(dut_log.size()), 64'd0);

    // Randomized traffic against the model
    do_reset();
    burst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) burst = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 999);
      if (r == 999) begin
        #2 aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
      end else begin
        k = $urandom_range(0, 9);
        if (k == 0 && rto_time > 64'd4) ts = rto_time - 64'($urandom_range(0, 3));
        else ts = rto_time + 64'($urandom_range(0, burst ? 300 : 60));
        cyc($urandom_range(0, 99) < (burst ? 90 : 40), {ts, $urandom, $urandom},
            (r >= 3 && r < 8), (r < 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
